// File: rtl/insmem_loader.sv
// Instruction-memory loader: packs a UART byte stream big-endian into 32-bit words and writes them from address 0.
// Latency: a word is written (mem_we) in the cycle after its 4th byte is sampled; done/error follow one edge after the last write.
// Backpressure: none; rx_valid is accepted on every LOAD cycle and busy stalls the core for the whole load.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 1-cycle pulse, begins a load from IDLE, DONE or ERR
//   rx_data, rx_valid     received byte and its 1-cycle strobe
//   mem_we/addr/wdata     instruction memory write port, one pulse per word, byte address = word index << 2
//   busy, done, error     load in progress / ended cleanly / overflow or checksum failure
//   word_count            words written in the current or last load
//
// Optional feature: define LOADER_CHECKSUM_EN to require an XOR checksum byte after the terminator word.
module insmem_loader #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] END_WORD   = 32'hFFFF_FFFF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   word_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
`ifdef LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERR
    } state_t;

    // Index of the last word slot; a non-terminator written here is an overflow.
    localparam logic [ADDR_WIDTH:0] LAST_IDX = {1'b0, {ADDR_WIDTH{1'b1}}};

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  byte_cnt;
    logic [23:0] shreg;
    logic        start_load;
    logic        wr_term;
    logic        wr_last;
    logic        accept;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign start_load = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));

    // The write cycle of the final word (terminator or last slot) closes the load;
    // any byte arriving in that cycle is not part of the image.
    assign wr_term = mem_we && (mem_wdata == END_WORD);
    assign wr_last = wr_term || (mem_we && (word_count == LAST_IDX));
    assign accept  = (state == S_LOAD) && rx_valid && !wr_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (wr_term) begin
`ifdef LOADER_CHECKSUM_EN
                    // A checksum byte sent back-to-back with the terminator lands
                    // in the write cycle; judge it here so it is not lost.
                    if (rx_valid) begin
                        state_nxt = (rx_data == csum) ? S_DONE : S_ERR;
                    end else begin
                        state_nxt = S_CHK;
                    end
`else
                    state_nxt = S_DONE;
`endif
                end else if (wr_last) begin
                    state_nxt = S_ERR;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (rx_valid) begin
                    state_nxt = (rx_data == csum) ? S_DONE : S_ERR;
                end
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt   <= 2'd0;
            shreg      <= 24'd0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            word_count <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum       <= 8'd0;
`endif
        end else begin
            mem_we <= 1'b0;
            if (start_load) begin
                byte_cnt   <= 2'd0;
                word_count <= '0;
`ifdef LOADER_CHECKSUM_EN
                csum       <= 8'd0;
`endif
            end
            // word_count doubles as the write index; it advances once the write
            // cycle is over. The load ends at the last slot, so it never wraps.
            if (mem_we) begin
                word_count <= word_count + 1'b1;
            end
            if (accept) begin
                shreg    <= {shreg[15:0], rx_data};
                byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                csum     <= csum ^ rx_data;
`endif
                if (byte_cnt == 2'd3) begin
                    mem_we    <= 1'b1;
                    mem_wdata <= {shreg, rx_data};
                    mem_addr  <= {{(30-ADDR_WIDTH){1'b0}}, word_count[ADDR_WIDTH-1:0], 2'b00};
                end
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    assign busy = (state == S_LOAD) || (state == S_CHK);
`else
    assign busy = (state == S_LOAD);
`endif
    assign done  = (state == S_DONE);
    assign error = (state == S_ERR);

endmodule

// File: tb/tb_insmem_loader.sv
// Testbench for insmem_loader: expected memory writes are queued as stimulus is issued
// and popped by an independent monitor whenever mem_we is seen.
module tb_insmem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic [8:0]  word_count;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    logic [7:0] stream2 [8] = '{8'h20, 8'h10, 8'h00, 8'h04, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    insmem_loader #(.ADDR_WIDTH(8), .END_WORD(32'hFFFF_FFFF)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every write the DUT issues must match the head of the queue.
    always @(negedge clk) begin
        wr_t e;
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got addr %h data %h, required no write (t=%0t)", mem_addr, mem_wdata, $time);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", mem_addr, e.addr);
                check("wr_data", mem_wdata, e.data);
            end
        end
    end

    task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // All stimulus tasks start and end on a falling edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[31-8*i -: 8], gap);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_levels(input string nm, input logic b, input logic d, input logic e, input logic [8:0] wc);
        check({nm, "_busy"}, 32'(busy), 32'(b));
        check({nm, "_done"}, 32'(done), 32'(d));
        check({nm, "_error"}, 32'(error), 32'(e));
        check({nm, "_word_count"}, 32'(word_count), 32'(wc));
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check_levels("rst", 1'b0, 1'b0, 1'b0, 9'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Bytes before start are ignored: no write may appear
        send_word(32'hAABBCCDD, 0);
        repeat (2) @(negedge clk);
        check_levels("idle_bytes", 1'b0, 1'b0, 1'b0, 9'd0);

        // Reset in the middle of a load, right as a write goes out
        pulse_start();
        check("load_busy", 32'(busy), 32'd1);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        rx_data  = 8'h44;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        check("we_before_rst", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_mem_we", 32'(mem_we), 32'd0);
        check("midrst_mem_wdata", mem_wdata, 32'd0);
        check_levels("midrst", 1'b0, 1'b0, 1'b0, 9'd0);
        rx_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_byte(8'h55, 2);
        check_levels("post_rst", 1'b0, 1'b0, 1'b0, 9'd0);

        // Basic load, back-to-back bytes
        expect_wr(32'h0, 32'h2010_0004);
        expect_wr(32'h4, 32'hFFFF_FFFF);
        pulse_start();
        for (int i = 0; i < 8; i++) send_byte(stream2[i], 0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h34, 0);
`endif
        repeat (2) @(negedge clk);
        check_levels("basic", 1'b0, 1'b1, 1'b0, 9'd2);
        send_byte(8'h99, 1);
        check("basic_after_done", 32'(done), 32'd1);

        // Same stream with idle gaps and a stray start during LOAD
        expect_wr(32'h0, 32'h2010_0004);
        expect_wr(32'h4, 32'hFFFF_FFFF);
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            send_byte(stream2[i], (i * 3) % 8);
            if (i == 5) pulse_start();
        end
`ifdef LOADER_CHECKSUM_EN
        repeat (3) @(negedge clk);
        send_byte(8'h34, 0);
`endif
        repeat (2) @(negedge clk);
        check_levels("gaps", 1'b0, 1'b1, 1'b0, 9'd2);

        // Reload after DONE: counters restart and writes begin at 0
        pulse_start();
        check_levels("reload_start", 1'b1, 1'b0, 1'b0, 9'd0);
        expect_wr(32'h0, 32'hDEAD_BEEF);
        expect_wr(32'h4, 32'hFFFF_FFFF);
        send_word(32'hDEADBEEF, 1);
        send_word(32'hFFFFFFFF, 0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h22, 0);
`endif
        repeat (2) @(negedge clk);
        check_levels("reload", 1'b0, 1'b1, 1'b0, 9'd2);

`ifdef LOADER_CHECKSUM_EN
        // Wrong checksum byte
        expect_wr(32'h0, 32'h2010_0004);
        expect_wr(32'h4, 32'hFFFF_FFFF);
        pulse_start();
        for (int i = 0; i < 8; i++) send_byte(stream2[i], 0);
        repeat (2) @(negedge clk);
        check("chk_wait_busy", 32'(busy), 32'd1);
        send_byte(8'h35, 0);
        repeat (2) @(negedge clk);
        check_levels("bad_csum", 1'b0, 1'b0, 1'b1, 9'd2);
`endif

        // Overflow: 256 zero words, no terminator
        pulse_start();
        for (int i = 0; i < 256; i++) begin
            expect_wr(32'(i) << 2, 32'h0);
            send_word(32'h0, 0);
        end
        repeat (2) @(negedge clk);
        check_levels("overflow", 1'b0, 1'b0, 1'b1, 9'd256);
        check("overflow_last_addr", mem_addr, 32'h3FC);
        send_word(32'h0, 0);
        send_word(32'h12345678, 1);
        repeat (2) @(negedge clk);
        check_levels("overflow_hold", 1'b0, 1'b0, 1'b1, 9'd256);

        // Restart from ERR clears error and the count
        pulse_start();
        check_levels("restart_err", 1'b1, 1'b0, 1'b0, 9'd0);

        repeat (3) @(negedge clk);
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
